// File: rtl/mole_scheduler.sv
// Four-lane reaction game sequencer: picks the lit lane, times lit/dark windows,
// detects lane presses, keeps score and runs the idle/gap/lit game flow.
module mole_scheduler #(
    parameter int unsigned ON_CYCLES   = 20000000,
    parameter int unsigned OFF_CYCLES  = 5000000,
    parameter int unsigned HOLDOFF     = 1000,
    parameter int unsigned START_SCORE = 3,
    parameter int unsigned WIN_SCORE   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] btn,
    output logic [3:0] lamp,
    output logic [7:0] score,
    output logic [5:0] score_onehot,
    output logic       ingame,
    output logic       won,
    output logic       lost
);

    localparam int unsigned T_MAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [TIMER_W-1:0] ON_LAST   = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST  = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLDOFF);
    localparam logic [7:0]         START_VAL = 8'(START_SCORE);
    localparam logic [7:0]         WIN_VAL   = 8'(WIN_SCORE);
    localparam logic [7:0]         LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_LIT  = 2'd2
    } state_t;

    function automatic logic [5:0] onehot_mod6(input logic [7:0] value);
        logic [7:0] rem;
        rem = value % 8'd6;
        return 6'b000001 << rem[2:0];
    endfunction

    state_t               state_r;
    logic [TIMER_W-1:0]   timer_r;
    logic [HOLD_W-1:0]    hold_r;
    logic [3:0]           btn_prev_r;
    logic [7:0]           lfsr_r;
    logic [1:0]           last_lane_r;
    logic [3:0]           lamp_r;
    logic [7:0]           score_r;
    logic [5:0]           onehot_r;
    logic                 ingame_r;
    logic                 won_r;
    logic                 lost_r;

    logic [3:0]           press_s;
    logic [7:0]           lfsr_next_s;
    logic [1:0]           pick_s;
    logic [1:0]           sel_lane_s;
    logic [3:0]           lit_mask_s;
    logic                 hit_s;
    logic                 wrong_s;
    logic                 timeout_s;
    logic [7:0]           score_inc_s;
    logic [7:0]           score_dec_s;
    logic [7:0]           score_nxt_s;
    logic                 leave_lit_s;
    logic                 win_s;
    logic                 lose_s;

    // Press edges, next LFSR value, next lane and the lit-window score outcome.
    always_comb begin
        press_s     = btn_prev_r & ~btn;
        lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        pick_s      = lfsr_r[1:0];
        if (pick_s == last_lane_r) begin
            sel_lane_s = pick_s + 2'd1;
        end else begin
            sel_lane_s = pick_s;
        end
        lit_mask_s  = 4'b0001 << last_lane_r;
        hit_s       = |(press_s & lit_mask_s);
        wrong_s     = |(press_s & ~lit_mask_s);
        timeout_s   = (timer_r == ON_LAST);
        score_inc_s = (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
        score_dec_s = (score_r == 8'd0) ? 8'd0 : score_r - 8'd1;
        // A hit wins over a timeout on the same cycle; wrong lanes cost one point at most.
        if (hit_s) begin
            score_nxt_s = score_inc_s;
            leave_lit_s = 1'b1;
        end else if (timeout_s) begin
            score_nxt_s = score_dec_s;
            leave_lit_s = 1'b1;
        end else if (wrong_s) begin
            score_nxt_s = score_dec_s;
            leave_lit_s = 1'b0;
        end else begin
            score_nxt_s = score_r;
            leave_lit_s = 1'b0;
        end
        win_s  = (score_nxt_s >= WIN_VAL);
        lose_s = (score_nxt_s == 8'd0);
    end

    // Game state machine with registered outputs; frozen whenever en is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            hold_r      <= '0;
            btn_prev_r  <= 4'hF;
            lfsr_r      <= LFSR_SEED;
            last_lane_r <= 2'd0;
            lamp_r      <= 4'hF;
            score_r     <= 8'd0;
            onehot_r    <= 6'b000001;
            ingame_r    <= 1'b0;
            won_r       <= 1'b0;
            lost_r      <= 1'b0;
        end else if (en) begin
            btn_prev_r <= btn;
            lfsr_r     <= lfsr_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (hold_r != HOLD_MAX) begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end else if (|press_s) begin
                        state_r  <= ST_GAP;
                        timer_r  <= '0;
                        lamp_r   <= 4'h0;
                        ingame_r <= 1'b1;
                        score_r  <= START_VAL;
                        onehot_r <= onehot_mod6(START_VAL);
                        won_r    <= 1'b0;
                        lost_r   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (timer_r == OFF_LAST) begin
                        state_r     <= ST_LIT;
                        timer_r     <= '0;
                        last_lane_r <= sel_lane_s;
                        lamp_r      <= 4'b0001 << sel_lane_s;
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_LIT: begin
                    score_r  <= score_nxt_s;
                    onehot_r <= onehot_mod6(score_nxt_s);
                    if (win_s || lose_s) begin
                        state_r  <= ST_IDLE;
                        hold_r   <= '0;
                        lamp_r   <= 4'hF;
                        ingame_r <= 1'b0;
                        won_r    <= win_s;
                        lost_r   <= lose_s & ~win_s;
                    end else if (leave_lit_s) begin
                        state_r <= ST_GAP;
                        timer_r <= '0;
                        lamp_r  <= 4'h0;
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hold_r   <= '0;
                    lamp_r   <= 4'hF;
                    ingame_r <= 1'b0;
                end
            endcase
        end
    end

    assign lamp         = lamp_r;
    assign score        = score_r;
    assign score_onehot = onehot_r;
    assign ingame       = ingame_r;
    assign won          = won_r;
    assign lost         = lost_r;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: fixed start-up vectors, directed game scenarios
// and a randomized run compared against a behavioural game model.
module tb_mole_scheduler;

    localparam int ON_C    = 8;
    localparam int OFF_C   = 4;
    localparam int HOLD_C  = 16;
    localparam int START_C = 3;
    localparam int WIN_C   = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] btn;
    logic [3:0] lamp;
    logic [7:0] score;
    logic [5:0] score_onehot;
    logic       ingame;
    logic       won;
    logic       lost;

    always #5 clk = ~clk;

    mole_scheduler #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .HOLDOFF    (HOLD_C),
        .START_SCORE(START_C),
        .WIN_SCORE  (WIN_C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .btn         (btn),
        .lamp        (lamp),
        .score       (score),
        .score_onehot(score_onehot),
        .ingame      (ingame),
        .won         (won),
        .lost        (lost)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural game model: phase 0 idle, 1 dark gap, 2 lamp lit.
    int       m_phase;
    int       m_t;
    int       m_hold;
    int       m_score;
    int       m_last;
    int       m_lfsr;
    bit       m_won;
    bit       m_lost;
    bit [3:0] m_prev;

    typedef struct {
        logic       rst_v;
        logic [3:0] btn_v;
        int         reps;
        logic [3:0] exp_lamp;
        logic [7:0] exp_score;
        logic [5:0] exp_onehot;
        logic       exp_ingame;
    } vec_t;

    vec_t vecs[6];

    function automatic int lfsr_adv(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_hold = 0; m_score = 0; m_last = 0;
        m_lfsr = 165; m_won = 1'b0; m_lost = 1'b0; m_prev = 4'hF;
    endtask

    task automatic model_step(input logic r, input logic e, input logic [3:0] b);
        bit [3:0] press;
        int cur;
        int lane;
        if (!r) begin
            model_reset();
            return;
        end
        if (!e) return;
        press  = m_prev & ~b;
        m_prev = b;
        cur    = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        case (m_phase)
            0: begin
                if (m_hold == HOLD_C && press != 4'h0) begin
                    m_phase = 1; m_t = 0; m_score = START_C; m_won = 1'b0; m_lost = 1'b0;
                end else if (m_hold < HOLD_C) begin
                    m_hold++;
                end
            end
            1: begin
                m_t++;
                if (m_t == OFF_C) begin
                    lane = cur % 4;
                    if (lane == m_last) lane = (lane + 1) % 4;
                    m_last = lane; m_phase = 2; m_t = 0;
                end
            end
            2: begin
                m_t++;
                if (press[m_last]) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_phase = 1; m_t = 0;
                end else if (m_t == ON_C) begin
                    if (m_score > 0) m_score--;
                    m_phase = 1; m_t = 0;
                end else if (press != 4'h0) begin
                    if (m_score > 0) m_score--;
                end
                if (m_score >= WIN_C) begin
                    m_phase = 0; m_won = 1'b1; m_hold = 0;
                end else if (m_score == 0) begin
                    m_phase = 0; m_lost = 1'b1; m_hold = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] el;
        logic [5:0] eo;
        el = (m_phase == 0) ? 4'hF : (m_phase == 1) ? 4'h0 : (4'b0001 << m_last);
        eo = 6'b000001 << (m_score % 6);
        check({tag, ".lamp"},   32'(lamp),         32'(el));
        check({tag, ".score"},  32'(score),        32'(m_score));
        check({tag, ".onehot"}, 32'(score_onehot), 32'(eo));
        check({tag, ".ingame"}, 32'(ingame),       32'(m_phase != 0));
        check({tag, ".won"},    32'(won),          32'(m_won));
        check({tag, ".lost"},   32'(lost),         32'(m_lost));
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] b);
        @(negedge clk);
        reset = r; en = e; btn = b;
        @(posedge clk);
        model_step(r, e, b);
        #1;
    endtask

    task automatic wait_lit(input string tag);
        int n = 0;
        while (m_phase != 2 && n < 40) begin
            cyc(1'b1, 1'b1, 4'hF);
            check_model(tag);
            n++;
        end
        check({tag, ".reached_lit"}, 32'(m_phase == 2), 32'd1);
        check({tag, ".one_lamp"}, 32'($countones(lamp)), 32'd1);
    endtask

    task automatic restart(input string tag);
        repeat (HOLD_C + 1) begin
            cyc(1'b1, 1'b1, 4'hF);
            check_model(tag);
        end
        cyc(1'b1, 1'b1, 4'hE);
        check_model(tag);
        check({tag, ".start_ingame"}, 32'(ingame), 32'd1);
        check({tag, ".start_score"},  32'(score),  32'(START_C));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lit_n;
        int k;
        logic [3:0] hb;
        logic [3:0] wb;
        logic [3:0] el;
        logic r;
        logic e;
        logic [3:0] b;

        reset = 1'b0; en = 1'b1; btn = 4'hF;
        model_reset();

        // Start-up: reset, early press ignored, press after holdoff starts a game.
        vecs[0] = '{1'b0, 4'hF, 2,  4'hF, 8'd0, 6'b000001, 1'b0};
        vecs[1] = '{1'b1, 4'hF, 4,  4'hF, 8'd0, 6'b000001, 1'b0};
        vecs[2] = '{1'b1, 4'hE, 1,  4'hF, 8'd0, 6'b000001, 1'b0};
        vecs[3] = '{1'b1, 4'hF, 14, 4'hF, 8'd0, 6'b000001, 1'b0};
        vecs[4] = '{1'b1, 4'hE, 1,  4'h0, 8'd3, 6'b001000, 1'b1};
        vecs[5] = '{1'b1, 4'hE, 3,  4'h0, 8'd3, 6'b001000, 1'b1};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].reps; j++) begin
                cyc(vecs[i].rst_v, 1'b1, vecs[i].btn_v);
                check($sformatf("vec%0d.lamp", i),   32'(lamp),         32'(vecs[i].exp_lamp));
                check($sformatf("vec%0d.score", i),  32'(score),        32'(vecs[i].exp_score));
                check($sformatf("vec%0d.onehot", i), 32'(score_onehot), 32'(vecs[i].exp_onehot));
                check($sformatf("vec%0d.ingame", i), 32'(ingame),       32'(vecs[i].exp_ingame));
                check_model($sformatf("vec%0d", i));
            end
        end

        // Fourth gap cycle lights exactly one lane.
        cyc(1'b1, 1'b1, 4'hF);
        check_model("s1");
        check("s1.one_lamp", 32'($countones(lamp)), 32'd1);

        // Hit, then hold the button through the next lit window.
        k  = m_last;
        hb = ~(4'b0001 << k);
        cyc(1'b1, 1'b1, hb);
        check_model("s2");
        check("s2.hit_score", 32'(score), 32'd4);
        check("s2.hit_lamp",  32'(lamp),  32'd0);
        repeat (4) begin cyc(1'b1, 1'b1, hb); check_model("s2g"); end
        check("s2.new_lane_differs", 32'(lamp[k]), 32'd0);
        check("s2.new_one_lamp", 32'($countones(lamp)), 32'd1);
        repeat (8) begin cyc(1'b1, 1'b1, hb); check_model("s2h"); end
        check("s2.held_no_score", 32'(score), 32'd3);

        // Timeout: lamp lit for exactly ON cycles, score drops by one.
        wait_lit("s3a");
        lit_n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 4'hF);
            check_model("s3a");
            if (lamp == 4'h0) break;
            lit_n++;
        end
        check("s3.lit_cycles", 32'(lit_n), 32'(ON_C));
        check("s3.timeout_score", 32'(score), 32'd2);

        // Two wrong lanes at once cost one point; hit plus wrong nets +1.
        wait_lit("s3b");
        k  = m_last;
        wb = 4'hF; wb[(k + 1) % 4] = 1'b0; wb[(k + 2) % 4] = 1'b0;
        el = 4'b0001 << k;
        cyc(1'b1, 1'b1, wb);
        check_model("s3b");
        check("s3.wrong_score", 32'(score), 32'd1);
        check("s3.wrong_lamp",  32'(lamp),  32'(el));
        cyc(1'b1, 1'b1, 4'hF);
        check_model("s3b");
        check("s3.wrong_once", 32'(score), 32'd1);
        hb = 4'hF; hb[k] = 1'b0; hb[(k + 1) % 4] = 1'b0;
        cyc(1'b1, 1'b1, hb);
        check_model("s3c");
        check("s3.hit_wrong_score", 32'(score), 32'd2);
        check("s3.hit_wrong_lamp",  32'(lamp),  32'd0);

        // Lose: wrong press to 1, then timeout to 0.
        wait_lit("s4l");
        k  = m_last;
        wb = 4'hF; wb[(k + 3) % 4] = 1'b0;
        cyc(1'b1, 1'b1, wb);
        check_model("s4l");
        check("s4.pre_lose_score", 32'(score), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 4'hF);
            check_model("s4l");
            if (m_phase == 0) break;
        end
        check("s4.lose_score",  32'(score),  32'd0);
        check("s4.lose_lost",   32'(lost),   32'd1);
        check("s4.lose_won",    32'(won),    32'd0);
        check("s4.lose_ingame", 32'(ingame), 32'd0);
        check("s4.lose_lamp",   32'(lamp),   32'hF);

        // Win: hits up to WIN_SCORE.
        restart("s4w");
        for (int i = 0; i < 20 && m_score < WIN_C; i++) begin
            wait_lit("s4w");
            hb = 4'hF; hb[m_last] = 1'b0;
            cyc(1'b1, 1'b1, hb);
            check_model("s4w");
        end
        check("s4.win_ingame", 32'(ingame),       32'd0);
        check("s4.win_won",    32'(won),          32'd1);
        check("s4.win_lost",   32'(lost),         32'd0);
        check("s4.win_lamp",   32'(lamp),         32'hF);
        check("s4.win_score",  32'(score),        32'd12);
        check("s4.win_onehot", 32'(score_onehot), 32'b000001);

        // Enable gating: ON enabled cycles span twice as many clocks.
        restart("s5");
        wait_lit("s5");
        lit_n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, (i % 2 == 1), 4'hF);
            check_model("s5");
            if (lamp == 4'h0) break;
            lit_n++;
        end
        check("s5.lit_clocks", 32'(lit_n), 32'(2 * ON_C));
        check("s5.timeout_score", 32'(score), 32'd2);
        wait_lit("s5b");
        hb = 4'hF; hb[m_last] = 1'b0;
        cyc(1'b1, 1'b0, hb);
        check_model("s5b");
        check("s5.frozen_score", 32'(score), 32'd2);
        cyc(1'b1, 1'b0, hb);
        cyc(1'b1, 1'b1, hb);
        check_model("s5b");
        check("s5.held_hit_score", 32'(score), 32'd3);
        check("s5.held_hit_lamp",  32'(lamp),  32'd0);
        cyc(1'b1, 1'b1, hb);
        cyc(1'b1, 1'b1, hb);
        check_model("s5b");
        check("s5.held_scores_once", 32'(score), 32'd3);

        // Reset mid-lit with score 7, then no start before the holdoff expires.
        for (int i = 0; i < 20 && m_score < 7; i++) begin
            wait_lit("s6");
            hb = 4'hF; hb[m_last] = 1'b0;
            cyc(1'b1, 1'b1, hb);
            check_model("s6");
        end
        check("s6.score7", 32'(score), 32'd7);
        wait_lit("s6");
        cyc(1'b1, 1'b1, 4'hF);
        cyc(1'b0, 1'b0, 4'hE);
        check_model("s6r");
        check("s6.rst_lamp",   32'(lamp),         32'hF);
        check("s6.rst_score",  32'(score),        32'd0);
        check("s6.rst_onehot", 32'(score_onehot), 32'b000001);
        check("s6.rst_ingame", 32'(ingame),       32'd0);
        check("s6.rst_won",    32'(won),          32'd0);
        check("s6.rst_lost",   32'(lost),         32'd0);
        repeat (4)  begin cyc(1'b1, 1'b1, 4'hE); check_model("s6h"); end
        repeat (10) begin cyc(1'b1, 1'b1, 4'hF); check_model("s6h"); end
        cyc(1'b1, 1'b1, 4'hE);
        check_model("s6h");
        check("s6.no_start_c15", 32'(ingame), 32'd0);
        cyc(1'b1, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 4'hE);
        check_model("s6h");
        check("s6.start_c17", 32'(ingame), 32'd1);

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) != 0);
            e = ($urandom_range(0, 99) < 85);
            b = 4'hF;
            if (m_phase == 2 && $urandom_range(0, 5) == 0) b[m_last] = 1'b0;
            if ($urandom_range(0, 9) == 0) b = b & 4'($urandom);
            cyc(r, e, b);
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
